// File: rtl/seq_bin_to_bcd_display.sv
// Sequential 40-bit to six-digit display formatter using a bit-serial double-dabble engine.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zeros and floats the minus sign.
module seq_bin_to_bcd_display #(
    parameter int          BIN_W      = 20,
    parameter logic [5:0]  BLANK_CODE = 6'd63,
    parameter logic [5:0]  MINUS_CODE = 6'd62,
    parameter logic [5:0]  E_CODE     = 6'd14,
    parameter logic [5:0]  R_CODE     = 6'd27
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [39:0] i_value,
    input  logic        i_sign,
    input  logic        i_err,
    output logic        o_busy,
    output logic        o_done,
    output logic [5:0]  o_digit_pos,
    output logic [5:0]  o_ten_pos,
    output logic [5:0]  o_hundred_pos,
    output logic [5:0]  o_thousand_pos,
    output logic [5:0]  o_ten_thousand_pos,
    output logic [5:0]  o_hundred_thousand_pos
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_FMT} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [BIN_W-1:0]   r_bin;
    logic [23:0]        r_bcd;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sign;
    logic               r_bad;
    logic [23:0]        w_adj;
    logic [5:0]         w_code [6];
`ifdef LEADING_ZERO_BLANK_EN
    logic [2:0]         w_msd;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_CONV;
            S_CONV:  if (r_cnt == CNT_W'(1)) w_next = S_FMT;
            S_FMT:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign o_busy = (r_state != S_IDLE);

    always_comb begin
        for (int i = 0; i < 6; i++) begin
            w_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ? r_bcd[4*i +: 4] + 4'd3 : r_bcd[4*i +: 4];
        end
    end

    // Formatting: plain BCD codes, then sign placement, then the error pattern overrides all.
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            w_code[i] = {2'b00, r_bcd[4*i +: 4]};
        end
`ifdef LEADING_ZERO_BLANK_EN
        w_msd = 3'd0;
        for (int i = 1; i < 6; i++) begin
            if (r_bcd[4*i +: 4] != 4'd0) w_msd = 3'(i);
        end
        for (int i = 1; i < 6; i++) begin
            if (3'(i) > w_msd) w_code[i] = BLANK_CODE;
            if (r_sign && (3'(i) == w_msd + 3'd1)) w_code[i] = MINUS_CODE;
        end
`else
        if (r_sign) w_code[5] = MINUS_CODE;
`endif
        if (r_bad) begin
            w_code[5] = BLANK_CODE;
            w_code[4] = BLANK_CODE;
            w_code[3] = BLANK_CODE;
            w_code[2] = E_CODE;
            w_code[1] = R_CODE;
            w_code[0] = R_CODE;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_bin                  <= '0;
            r_bcd                  <= '0;
            r_cnt                  <= '0;
            r_sign                 <= 1'b0;
            r_bad                  <= 1'b0;
            o_done                 <= 1'b0;
            o_digit_pos            <= 6'd0;
            o_ten_pos              <= 6'd0;
            o_hundred_pos          <= 6'd0;
            o_thousand_pos         <= 6'd0;
            o_ten_thousand_pos     <= 6'd0;
            o_hundred_thousand_pos <= 6'd0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_bin  <= i_value[BIN_W-1:0];
                        r_bcd  <= '0;
                        r_cnt  <= CNT_W'(BIN_W);
                        // Negative zero displays as plain 0.
                        r_sign <= i_sign && (i_value != 40'd0);
                        r_bad  <= i_err || (i_value > 40'd999999) || (i_sign && (i_value > 40'd99999));
                    end
                end
                S_CONV: begin
                    {r_bcd, r_bin} <= {w_adj[22:0], r_bin, 1'b0};
                    r_cnt          <= r_cnt - CNT_W'(1);
                end
                S_FMT: begin
                    o_done                 <= 1'b1;
                    o_digit_pos            <= w_code[0];
                    o_ten_pos              <= w_code[1];
                    o_hundred_pos          <= w_code[2];
                    o_thousand_pos         <= w_code[3];
                    o_ten_thousand_pos     <= w_code[4];
                    o_hundred_thousand_pos <= w_code[5];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_bin_to_bcd_display.sv
// Bench for seq_bin_to_bcd_display: arithmetic display model, per-cycle compare, directed vectors.
module tb_seq_bin_to_bcd_display;

    localparam int          LAT = 22;
    localparam logic [5:0]  BL  = 6'd63;
    localparam logic [5:0]  MI  = 6'd62;
    localparam logic [5:0]  EC  = 6'd14;
    localparam logic [5:0]  RC  = 6'd27;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic [39:0] i_value = '0;
    logic        i_sign = 1'b0;
    logic        i_err = 1'b0;
    logic        o_busy, o_done;
    logic [5:0]  o_d0, o_d1, o_d2, o_d3, o_d4, o_d5;
    logic [35:0] digs;

    int checks = 0;
    int errors = 0;
    int prints = 0;

    seq_bin_to_bcd_display dut (
        .i_clk(clk), .i_reset(rst), .i_start(i_start), .i_value(i_value),
        .i_sign(i_sign), .i_err(i_err), .o_busy(o_busy), .o_done(o_done),
        .o_digit_pos(o_d0), .o_ten_pos(o_d1), .o_hundred_pos(o_d2),
        .o_thousand_pos(o_d3), .o_ten_thousand_pos(o_d4), .o_hundred_thousand_pos(o_d5)
    );

    assign digs = {o_d5, o_d4, o_d3, o_d2, o_d1, o_d0};

    always #5 clk = ~clk;

    function automatic logic [35:0] pack6(input logic [5:0] a, b, c, d, e, f);
        return {a, b, c, d, e, f};
    endfunction

    // Display rules stated arithmetically: decimal digits by division, overflow by range.
    function automatic logic [35:0] model(input logic [39:0] v, input logic s, input logic e);
        logic [5:0] c [6];
        longint t;
        int n;
        if (e || v > 40'd999999 || (s && v > 40'd99999))
            return pack6(BL, BL, BL, EC, RC, RC);
        t = longint'(v);
        n = 1;
        for (int i = 0; i < 6; i++) begin
            c[i] = 6'(t % 10);
            if (i > 0 && c[i] != 6'd0) n = i + 1;
            t = t / 10;
        end
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = 0; i < 6; i++) if (i >= n) c[i] = BL;
        if (s && v != 40'd0) c[n] = MI;
`else
        if (s && v != 40'd0) c[5] = MI;
`endif
        return pack6(c[5], c[4], c[3], c[2], c[1], c[0]);
    endfunction

    // Model timeline: m_cyc is the cycle index since the accepting edge (0 = idle).
    int          m_cyc = 0;
    logic [39:0] m_val = '0;
    logic        m_sign = 1'b0;
    logic        m_err = 1'b0;
    logic [35:0] m_digs = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cyc  = 0;
            m_digs = '0;
        end else if ((m_cyc == 0 || m_cyc == LAT) && i_start) begin
            m_cyc  = 1;
            m_val  = i_value;
            m_sign = i_sign;
            m_err  = i_err;
        end else if (m_cyc != 0 && m_cyc < LAT) begin
            m_cyc = m_cyc + 1;
            if (m_cyc == LAT) m_digs = model(m_val, m_sign, m_err);
        end else begin
            m_cyc = 0;
        end
    end

    always @(negedge clk) begin
        logic eb, ed;
        eb = (m_cyc >= 1 && m_cyc < LAT);
        ed = (m_cyc == LAT);
        checks++;
        if (o_busy !== eb || o_done !== ed || digs !== m_digs) begin
            errors++;
            if (prints < 20) begin
                prints++;
                $display("FAIL cycle_cmp t=%0t busy=%b exp=%b done=%b exp=%b digits=%h exp=%h",
                         $time, o_busy, eb, o_done, ed, digs, m_digs);
            end
        end
    end

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic pulse_start(input logic [39:0] v, input logic s, input logic e);
        i_start = 1'b1;
        i_value = v;
        i_sign  = s;
        i_err   = e;
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    // Returns cycles counted from the accepting edge to the done cycle; -1 on timeout.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (o_done === 1'b1) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) begin
            errors++;
            $display("FAIL done_timeout actual=no_done expected=done_within_60");
        end
    endtask

    task automatic run(input logic [39:0] v, input logic s, input logic e,
                       input string name, input logic [35:0] exp);
        int lat;
        @(posedge clk);
        #1;
        pulse_start(v, s, e);
        wait_done(lat);
        chk({name, "_latency"}, 36'(lat), 36'(LAT));
        chk(name, digs, exp);
    endtask

    initial begin
        int lat;
        int done_seen;

        chk("model_123456", model(40'd123456, 1'b0, 1'b0), pack6(6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6));
        chk("model_err", model(40'd1000000, 1'b0, 1'b0), pack6(BL, BL, BL, EC, RC, RC));
`ifdef LEADING_ZERO_BLANK_EN
        chk("model_neg42", model(40'd42, 1'b1, 1'b0), pack6(BL, BL, BL, MI, 6'd4, 6'd2));
        chk("model_negzero", model(40'd0, 1'b1, 1'b0), pack6(BL, BL, BL, BL, BL, 6'd0));
`else
        chk("model_neg42", model(40'd42, 1'b1, 1'b0), pack6(MI, 6'd0, 6'd0, 6'd0, 6'd4, 6'd2));
        chk("model_negzero", model(40'd0, 1'b1, 1'b0), pack6(6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0));
`endif

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_digits", digs, 36'd0);
        chk("reset_busy_done", {34'd0, o_busy, o_done}, 36'd0);

        // Abort a conversion by reset in its tenth cycle.
        @(posedge clk);
        #1;
        pulse_start(40'd123456, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        done_seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (o_done === 1'b1) done_seen = 1;
        end
        chk("abort_no_done", 36'(done_seen), 36'd0);
        chk("abort_digits", digs, 36'd0);

        run(40'd123456, 1'b0, 1'b0, "v123456", pack6(6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6));
`ifdef LEADING_ZERO_BLANK_EN
        run(40'd42, 1'b1, 1'b0, "neg42", pack6(BL, BL, BL, MI, 6'd4, 6'd2));
        run(40'd0, 1'b1, 1'b0, "negzero", pack6(BL, BL, BL, BL, BL, 6'd0));
        run(40'd99999, 1'b1, 1'b0, "neg99999", pack6(MI, 6'd9, 6'd9, 6'd9, 6'd9, 6'd9));
        run(40'd700, 1'b0, 1'b0, "v700", pack6(BL, BL, BL, 6'd7, 6'd0, 6'd0));
`else
        run(40'd42, 1'b1, 1'b0, "neg42", pack6(MI, 6'd0, 6'd0, 6'd0, 6'd4, 6'd2));
        run(40'd0, 1'b1, 1'b0, "negzero", pack6(6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0));
        run(40'd99999, 1'b1, 1'b0, "neg99999", pack6(MI, 6'd9, 6'd9, 6'd9, 6'd9, 6'd9));
        run(40'd700, 1'b0, 1'b0, "v700", pack6(6'd0, 6'd0, 6'd0, 6'd7, 6'd0, 6'd0));
`endif
        run(40'd1000000, 1'b0, 1'b0, "ovf_1000000", pack6(BL, BL, BL, EC, RC, RC));
        run(40'd150000, 1'b1, 1'b0, "ovf_neg150000", pack6(BL, BL, BL, EC, RC, RC));
        run(40'd5, 1'b0, 1'b1, "err_5", pack6(BL, BL, BL, EC, RC, RC));
        run(40'h10_0000_0003, 1'b0, 1'b0, "ovf_highbit", pack6(BL, BL, BL, EC, RC, RC));

        // Start while busy is ignored; start in the done cycle is accepted.
        @(posedge clk);
        #1;
        pulse_start(40'd314159, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        pulse_start(40'd7, 1'b1, 1'b1);
        wait_done(lat);
        chk("busy_start_ignored", digs, pack6(6'd3, 6'd1, 6'd4, 6'd1, 6'd5, 6'd9));
        pulse_start(40'd999999, 1'b0, 1'b0);
        wait_done(lat);
        chk("b2b_latency", 36'(lat), 36'(LAT));
        chk("b2b_999999", digs, pack6(6'd9, 6'd9, 6'd9, 6'd9, 6'd9, 6'd9));

        repeat (5) @(posedge clk);
        chk("hold_after_done", digs, pack6(6'd9, 6'd9, 6'd9, 6'd9, 6'd9, 6'd9));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
